nios_pio_edge_irq: RTL
======================

NIOS_PIO_EDGE_IRQ -- requirements
Module: nios_pio_edge_irq

Interface
REQ-001 DATA_WIDTH, default 8, PIO width in bits; legal range 1..32.
REQ-002 EDGE_TYPE, default 0, capture edge: 0=rising, 1=falling, 2=any. Other values are illegal.
REQ-003 OUT_RESET_VALUE, default 0, reset value of the output data register, DATA_WIDTH bits.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 address  input  2  register select: 0=data, 1=direction, 2=irqmask, 3=edgecapture.
REQ-007 chipselect  input  1  slave select; qualifies writes only.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data; only bits [DATA_WIDTH-1:0] are used.
REQ-010 readdata  output  32  registered read data; bits above DATA_WIDTH are always 0.
REQ-011 in_port  input  DATA_WIDTH  asynchronous external inputs.
REQ-012 out_port  output  DATA_WIDTH  output data register.
REQ-013 out_en  output  DATA_WIDTH  per-bit drive enable; equals the direction register, 1=output.
REQ-014 irq  output  1  level interrupt request.

Function
REQ-015 A write is chipselect=1 and write_n=0 at a clk edge; it takes effect at that edge.
REQ-016 in_port passes through a 2-flop synchronizer (sync1, sync2); sync3 holds the previous sync2.
REQ-017 Edge detect per bit: rising = sync2 & ~sync3; falling = ~sync2 & sync3; any = sync2 ^ sync3.
REQ-018 A 2-bit prime counter counts up from 0 after reset and saturates at 3; edge detection is masked until the counter reaches 3, so no spurious capture occurs while the chain fills.
REQ-019 Edgecapture bit i is set at the edge where a qualified edge is detected on bit i, and holds until cleared.
REQ-020 Writing address 3 clears each edgecapture bit whose writedata bit is 1; bits written 0 are unchanged.
REQ-021 If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
REQ-022 Address 0 write loads out_port; address 1 write loads direction; address 2 write loads irqmask.
REQ-023 irq = OR over bits of (edgecapture & irqmask), driven from registers with no added delay.
REQ-024 readdata is updated at every clk edge from the current address, regardless of chipselect, so read latency is 1 cycle.
REQ-025 Read mux: addr 0 -> sync2 for input bits (direction=0) and out_port for output bits; addr 1 -> direction; addr 2 -> irqmask; addr 3 -> edgecapture.
REQ-026 Latency: an in_port change settled before edge E1 appears in sync2 after E2, appears in readdata (addr 0) after E3, sets edgecapture at E3, and raises irq after E3.
REQ-027 Changing irqmask with edgecapture already set affects irq in the cycle after the write edge; captured bits are not lost.

Reset
REQ-028 While reset_n=0, all of the following hold asynchronously: readdata=0, out_port=OUT_RESET_VALUE, direction=0 (out_en=0), irqmask=0, edgecapture=0, irq=0, sync1/sync2/sync3=0, prime counter=0.
REQ-029 Reset asserted mid-operation discards all pending captures and re-arms the prime counter.
REQ-030 Deassertion of reset_n is synchronous to clk at the system level; the block adds no deassertion synchronizer.

Verification
REQ-031 Reset with in_port=8'hFF held, EDGE_TYPE=0 -> edgecapture stays 8'h00 and irq stays 0 for 10 cycles.
REQ-032 EDGE_TYPE=0, irqmask=8'h01, in_port bit0 0->1 before E1 -> edgecapture=8'h01 at E3, irq=1 after E3; write 8'h01 to addr 3 -> irq=0 on the next cycle.
REQ-033 New rising edge detected on bit0 in the same cycle as a clear write of 8'h01 -> bit0 remains 1 and irq remains 1.
REQ-034 direction=8'hF0, out_port=8'hA5, in_port=8'h3C -> addr 0 read returns 32'h000000AC one cycle after the address is presented; out_en=8'hF0.
REQ-035 EDGE_TYPE=2, DATA_WIDTH=4, in_port pulses 0->1->0 on bit2 -> edgecapture=4'h4 and readdata[31:4]=0; irqmask=0 -> irq remains 0; writing irqmask=4'h4 -> irq=1 on the next cycle.

Source files
------------

// File: rtl/nios_pio_edge_irq.sv
// Avalon-MM parallel I/O port with a per-bit direction register and edge-capture interrupt.
// Input edges are detected after a two-flop synchronizer and held until software clears them.
module nios_pio_edge_irq #(
    parameter int                    DATA_WIDTH      = 8,
    parameter int                    EDGE_TYPE       = 0,
    parameter logic [DATA_WIDTH-1:0] OUT_RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] out_en,
    output logic                  irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_DIR  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [DATA_WIDTH-1:0] sync1, sync2, sync3;
    logic [DATA_WIDTH-1:0] direction, irq_mask, edge_capture;
    logic [DATA_WIDTH-1:0] edge_det, capture_next, wr_data, read_mux;
    logic [1:0]            prime_cnt;
    logic                  primed, wr_en;
    logic [31:0]           read_next;
    logic                  unused_writedata_bits;

    assign wr_en                 = chipselect & ~write_n;
    assign wr_data               = writedata[DATA_WIDTH-1:0];
    assign primed                = (prime_cnt == 2'd3);
    assign unused_writedata_bits = ^writedata;

    // Synchronizer chain; the prime counter keeps the filling chain from looking like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1     <= '0;
            sync2     <= '0;
            sync3     <= '0;
            prime_cnt <= 2'd0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            sync3 <= sync2;
            if (!primed)
                prime_cnt <= prime_cnt + 2'd1;
        end
    end

    always_comb begin
        edge_det = '0;
        if (primed) begin
            if (EDGE_TYPE == 1)
                edge_det = ~sync2 & sync3;
            else if (EDGE_TYPE == 2)
                edge_det = sync2 ^ sync3;
            else
                edge_det = sync2 & ~sync3;
        end
    end

    // Clear first, then OR in new edges so a simultaneous set wins.
    always_comb begin
        capture_next = edge_capture;
        if (wr_en && address == ADDR_EDGE)
            capture_next = capture_next & ~wr_data;
        capture_next = capture_next | edge_det;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port     <= OUT_RESET_VALUE;
            direction    <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            edge_capture <= capture_next;
            if (wr_en && address == ADDR_DATA)
                out_port <= wr_data;
            if (wr_en && address == ADDR_DIR)
                direction <= wr_data;
            if (wr_en && address == ADDR_MASK)
                irq_mask <= wr_data;
        end
    end

    always_comb begin
        read_mux = '0;
        unique case (address)
            ADDR_DATA: read_mux = (sync2 & ~direction) | (out_port & direction);
            ADDR_DIR:  read_mux = direction;
            ADDR_MASK: read_mux = irq_mask;
            ADDR_EDGE: read_mux = edge_capture;
            default:   read_mux = '0;
        endcase
        read_next                   = '0;
        read_next[DATA_WIDTH-1:0]   = read_mux;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else
            readdata <= read_next;
    end

    assign out_en = direction;
    assign irq    = |(edge_capture & irq_mask);

endmodule
